// File: rtl/posit_mant_add_norm.sv
// posit_mant_add_norm
//
// Purpose:
//   Two-stage mantissa add/subtract and normalise step of a posit adder.
//   Stage 1 forms the raw sum or difference of the aligned mantissas.
//   Stage 2 renormalises that sum so its leading one sits at bit 2N+2.
//   It also adjusts the scaled exponent to match, using signed
//   wrap-around arithmetic.
//   Valid/ready handshaking on both sides. Throughput is one beat per
//   cycle while out_ready is high.
//
// Parameters:
//   N   posit word width (mantissa datapath is 2N+3 bits)
//   es  exponent field width
//   Bs  regime-count width; the scaled exponent is Bs+es+2 bits, signed
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-high reset
//   in_valid   input beat valid
//   in_ready   input beat accepted when high together with in_valid
//   big_mant   larger-magnitude aligned mantissa
//   small_mant smaller mantissa, already right-aligned with sticky folded in
//   op_sub     1 = operand signs differ, so subtract
//   big_sign   sign of the larger operand
//   big_exp    signed scaled exponent of the larger operand
//   out_valid  result valid
//   out_ready  downstream accepts the result
//   out_mant   normalised mantissa, leading one at bit 2N+2
//   out_exp    signed adjusted exponent
//   out_sign   result sign
//   out_zero   (only with POSIT_MADD_ZERO_FLAG_EN) result was an exact zero
//
// Optional feature macro: POSIT_MADD_ZERO_FLAG_EN adds the out_zero port.

module posit_mant_add_norm #(
    parameter int N  = 8,
    parameter int es = 4,
    parameter int Bs = $clog2(N)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [2*N+2:0]            big_mant,
    input  logic [2*N+2:0]            small_mant,
    input  logic                      op_sub,
    input  logic                      big_sign,
    input  logic signed [Bs+es+1:0]   big_exp,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [2*N+2:0]            out_mant,
    output logic signed [Bs+es+1:0]   out_exp,
    output logic                      out_sign
`ifdef POSIT_MADD_ZERO_FLAG_EN
    ,
    output logic                      out_zero
`endif
);

    localparam int M  = 2*N+3;
    localparam int EW = Bs+es+2;

    logic                 s1_valid;
    logic [M:0]           s1_sum;
    logic                 s1_sign;
    logic signed [EW-1:0] s1_exp;

    logic                 s2_accept;
    logic                 sum_zero;
    int                   lz;
    logic [M-1:0]         norm_mant;
    logic signed [EW-1:0] norm_exp;
    logic                 norm_sign;

    // Stage 2 can take a new beat when it is empty or its beat is leaving.
    // Stage 1 can take a new beat when it is empty or it is moving into stage 2.
    assign s2_accept = !out_valid || out_ready;
    assign in_ready  = !s1_valid || s2_accept;

    // Stage 1: capture the add/subtract result.
    // The extra top bit catches the carry out of an addition.
    // Upstream guarantees big >= small, so a subtraction never borrows.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_sum   <= '0;
            s1_sign  <= 1'b0;
            s1_exp   <= '0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_sum  <= op_sub ? ({1'b0, big_mant} - {1'b0, small_mant})
                                  : ({1'b0, big_mant} + {1'b0, small_mant});
                s1_sign <= big_sign;
                s1_exp  <= big_exp;
            end
        end
    end

    assign sum_zero = (s1_sum == '0);

    // Leading-zero count of the low M bits of the sum.
    // The scan runs upward, so the last assignment comes from the highest
    // set bit. That bit fixes the shift distance.
    always_comb begin
        lz = 0;
        for (int i = 0; i < M; i++) begin
            if (s1_sum[i]) begin
                lz = M - 1 - i;
            end
        end
    end

    // Normalisation. On a carry out, shift right by one and fold the lost
    // bit into bit 0 as sticky.
    // Otherwise shift left until the leading one reaches the top.
    // An exact zero forces every field to zero, including the sign.
    always_comb begin
        norm_mant = '0;
        norm_exp  = '0;
        norm_sign = 1'b0;
        if (s1_sum[M]) begin
            norm_mant = s1_sum[M:1] | {{(M-1){1'b0}}, s1_sum[0]};
            norm_exp  = s1_exp + EW'(1);
            norm_sign = s1_sign;
        end else if (!sum_zero) begin
            norm_mant = s1_sum[M-1:0] << lz;
            norm_exp  = s1_exp - EW'(lz);
            norm_sign = s1_sign;
        end
    end

    // Stage 2: the output register.
    // While the downstream stalls it holds everything.
    // Reset drops any in-flight beat.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_mant  <= '0;
            out_exp   <= '0;
            out_sign  <= 1'b0;
`ifdef POSIT_MADD_ZERO_FLAG_EN
            out_zero  <= 1'b0;
`endif
        end else if (s2_accept) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_mant <= norm_mant;
                out_exp  <= norm_exp;
                out_sign <= norm_sign;
`ifdef POSIT_MADD_ZERO_FLAG_EN
                out_zero <= sum_zero;
`endif
            end
        end
    end

endmodule
